// File: rtl/seg_pkg.sv
// Segment pattern table (lit-high, bit7 = DP, bits 6:0 = g..a) and width helper
// shared by the 7-segment scan driver.
package seg_pkg;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_A    = 8'h77;
  localparam logic [7:0] SEG_B    = 8'h7C;
  localparam logic [7:0] SEG_C    = 8'h39;
  localparam logic [7:0] SEG_D    = 8'h5E;
  localparam logic [7:0] SEG_E    = 8'h79;
  localparam logic [7:0] SEG_F    = 8'h71;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational digit decoder: 4-bit code, DP and blank flag to a lit-high
// segment pattern. Polarity and registering are left to the caller.
module seg7_hex_decode
  import seg_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] code_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (code_i)
      4'd0:  seg_o = SEG_0;
      4'd1:  seg_o = SEG_1;
      4'd2:  seg_o = SEG_2;
      4'd3:  seg_o = SEG_3;
      4'd4:  seg_o = SEG_4;
      4'd5:  seg_o = SEG_5;
      4'd6:  seg_o = SEG_6;
      4'd7:  seg_o = SEG_7;
      4'd8:  seg_o = SEG_8;
      4'd9:  seg_o = SEG_9;
      4'd10: seg_o = HEX_EN ? SEG_A : SEG_DASH;
      4'd11: seg_o = HEX_EN ? SEG_B : SEG_DASH;
      4'd12: seg_o = HEX_EN ? SEG_C : SEG_DASH;
      4'd13: seg_o = HEX_EN ? SEG_D : SEG_DASH;
      4'd14: seg_o = HEX_EN ? SEG_E : SEG_DASH;
      4'd15: seg_o = HEX_EN ? SEG_F : SEG_DASH;
    endcase
    seg_o[7] = dp_i;
    // A blanked digit is fully dark, DP included.
    if (blank_i) begin
      seg_o = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered image,
// frame-synchronous image swap, leading-zero blanking and per-slot anode gap.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter bit          HEX_EN      = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lzb_en,
  output logic                    pending,
  output logic                    frame_start,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned IdxW = clog2(NUM_DIGITS);
  localparam int unsigned DivW = clog2(SCAN_DIV);

  localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [DivW-1:0]       DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [DivW-1:0]       DivBlank = DivW'(BLANK_CYC);
  localparam logic [7:0]            SegMask  = {8{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] AnMask   = {NUM_DIGITS{AN_ACT_LOW}};

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            pending_q, pending_d;
  logic            frame_start_q, frame_start_d;
  logic [7:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                    pend_lzb_q, pend_lzb_d;

  logic                    slot_end, wrap;
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp, src_blank;
  logic                    src_lzb, lzb_run;

  logic [3:0]            cur_code;
  logic                  cur_dp, cur_blank;
  logic [7:0]            cur_lit;
  logic [NUM_DIGITS-1:0] onehot;

  assign slot_end = (div_cnt_q == DivLast);
  assign wrap     = slot_end && (idx_q == IdxLast);

  // Image that becomes active at a wrap: a same-cycle load bypasses the buffer.
  always_comb begin
    src_digits = pend_digits_q;
    src_dp     = pend_dp_q;
    src_blank  = pend_blank_q;
    src_lzb    = pend_lzb_q;
    if (load) begin
      src_digits = digits;
      src_dp     = dp;
      src_blank  = blank;
      src_lzb    = lzb_en;
    end
    // Leading-zero blanking walks from the leftmost digit; digit 0 is never touched.
    lzb_run = src_lzb;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (lzb_run && (src_digits[4*i +: 4] == 4'd0) && !src_dp[i]) begin
        src_blank[i] = 1'b1;
      end else begin
        lzb_run = 1'b0;
      end
    end
  end

  always_comb begin
    div_cnt_d     = slot_end ? '0 : div_cnt_q + DivW'(1);
    idx_d         = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    frame_start_d = wrap;

    pending_d     = pending_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_lzb_d    = pend_lzb_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;

    if (load && !wrap) begin
      pend_digits_d = digits;
      pend_dp_d     = dp;
      pend_blank_d  = blank;
      pend_lzb_d    = lzb_en;
      pending_d     = 1'b1;
    end
    if (wrap) begin
      pending_d = 1'b0;
      if (load || pending_q) begin
        act_digits_d = src_digits;
        act_dp_d     = src_dp;
        act_blank_d  = src_blank;
      end
    end
  end

  always_comb begin
    cur_code  = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    onehot    = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_code  = act_digits_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = act_blank_q[i];
        onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .code_i  (cur_code),
    .dp_i    (cur_dp),
    .blank_i (cur_blank),
    .seg_o   (cur_lit)
  );

  // Anodes and segments stay dark for the first BLANK_CYC clocks of every slot.
  always_comb begin
    seg_d = SegMask;
    an_d  = AnMask;
    if (div_cnt_q >= DivBlank) begin
      seg_d = cur_lit ^ SegMask;
      an_d  = onehot ^ AnMask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= SegMask;
      an_q          <= AnMask;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_lzb_q    <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_lzb_q    <= pend_lzb_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign seg         = seg_q;
  assign an          = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus queues the expected {an, seg} for each slot of a frame;
// a monitor pops one entry at every anode turn-on and compares.
module tb_seg_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, load, lzb_en;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic        pending_a, frame_start_a, pending_b, frame_start_b;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;
  bit   gap_en = 1'b0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS (4), .SCAN_DIV (8), .BLANK_CYC (2),
    .HEX_EN (1'b1), .SEG_ACT_LOW (1'b1), .AN_ACT_LOW (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .load (load), .digits (digits), .dp (dp), .blank (blank),
    .lzb_en (lzb_en), .pending (pending_a), .frame_start (frame_start_a),
    .seg (seg_a), .an (an_a)
  );

  seg_scan_driver #(
    .NUM_DIGITS (4), .SCAN_DIV (8), .BLANK_CYC (2),
    .HEX_EN (1'b0), .SEG_ACT_LOW (1'b1), .AN_ACT_LOW (1'b1)
  ) dut_nohex (
    .clk (clk), .rst (rst), .load (load), .digits (digits), .dp (dp), .blank (blank),
    .lzb_en (lzb_en), .pending (pending_b), .frame_start (frame_start_b),
    .seg (seg_b), .an (an_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // segs = {slot3, slot2, slot1, slot0}
  task automatic push_frame(input bit to_b, input logic [31:0] segs);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.an  = ~(4'(1) << i);
      e.seg = segs[8*i +: 8];
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_start_a && cyc < 100);
    chk("frame_start_seen", 32'(frame_start_a), 32'd1);
  endtask

  // Monitor: slot start = anodes go from all-off to one-hot.
  initial begin
    exp_t e;
    logic [3:0] prev_an = 4'hF;
    int off_run = 0;
    int on_run  = 0;
    forever begin
      @(negedge clk);
      if (an_a != 4'hF && prev_an == 4'hF) begin
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          chk("slot_hex", {20'd0, an_a, seg_a}, {20'd0, e.an, e.seg});
        end
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          chk("slot_nohex", {20'd0, an_b, seg_b}, {20'd0, e.an, e.seg});
        end
        if (gap_en) chk("an_off_cycles", 32'(off_run), 32'd2);
      end
      if (an_a == 4'hF && prev_an != 4'hF && gap_en) begin
        chk("an_on_cycles", 32'(on_run), 32'd6);
      end
      if (an_a == 4'hF) off_run = (prev_an == 4'hF) ? off_run + 1 : 1;
      else              on_run  = (prev_an != 4'hF) ? on_run + 1 : 1;
      prev_an = an_a;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; load = 1'b0; digits = '0; dp = '0; blank = '0; lzb_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg_a), 32'hFF);
    chk("rst_an", 32'(an_a), 32'hF);
    chk("rst_pending", 32'(pending_a), 32'd0);
    chk("rst_frame_start", 32'(frame_start_a), 32'd0);
    chk("rst_pending_nohex", 32'(pending_b), 32'd0);

    // First frame after release shows the all-blank image.
    rst = 1'b0;
    push_frame(1'b0, 32'hFFFF_FFFF);
    wait_frame(cyc);
    chk("first_frame_cycles", 32'(cyc), 32'd32);

    // Mid-frame load waits for the wrap.
    load = 1'b1; digits = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    gap_en = 1'b1;
    chk("pending_after_load", 32'(pending_a), 32'd1);
    repeat (30) @(negedge clk);
    chk("pending_before_wrap", 32'(pending_a), 32'd1);
    @(negedge clk);
    chk("wrap_frame_start", 32'(frame_start_a), 32'd1);
    chk("wrap_frame_start_nohex", 32'(frame_start_b), 32'd1);
    chk("pending_at_wrap", 32'(pending_a), 32'd0);
    push_frame(1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    wait_frame(cyc);
    chk("frame_period", 32'(cyc), 32'd32);

    // Leading-zero blanking with a lit DP stopping the run; hex vs dash.
    load = 1'b1; digits = 16'h00A7; dp = 4'b0010; lzb_en = 1'b1;
    @(negedge clk);
    load = 1'b0; dp = '0; lzb_en = 1'b0;
    wait_frame(cyc);
    push_frame(1'b0, {8'hFF, 8'hFF, 8'h08, 8'hF8});
    push_frame(1'b1, {8'hFF, 8'hFF, 8'h3F, 8'hF8});

    // Two loads in one frame: last wins.
    load = 1'b1; digits = 16'h1111;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    load = 1'b1; digits = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    wait_frame(cyc);
    chk("pending_after_two_loads", 32'(pending_a), 32'd0);
    push_frame(1'b0, {8'hA4, 8'hA4, 8'hA4, 8'hA4});

    // Load in the wrap cycle goes straight to the active image.
    repeat (31) @(negedge clk);
    load = 1'b1; digits = 16'h5678;
    @(negedge clk);
    load = 1'b0;
    chk("wrap_load_frame_start", 32'(frame_start_a), 32'd1);
    chk("wrap_load_pending", 32'(pending_a), 32'd0);
    push_frame(1'b0, {8'h92, 8'h82, 8'hF8, 8'h80});
    @(negedge clk);
    chk("wrap_load_pending_later", 32'(pending_a), 32'd0);

    // Reset during slot 2 with an image pending.
    wait_frame(cyc);
    load = 1'b1; digits = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    gap_en = 1'b0;
    repeat (18) @(negedge clk);
    chk("pending_before_rst", 32'(pending_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_seg", 32'(seg_a), 32'hFF);
    chk("midrst_an", 32'(an_a), 32'hF);
    chk("midrst_pending", 32'(pending_a), 32'd0);
    rst = 1'b0;
    push_frame(1'b0, 32'hFFFF_FFFF);
    wait_frame(cyc);
    chk("post_rst_frame_cycles", 32'(cyc), 32'd32);
    push_frame(1'b0, 32'hFFFF_FFFF);
    wait_frame(cyc);

    chk("queue_hex_drained", 32'(q_a.size()), 32'd0);
    chk("queue_nohex_drained", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
